// File: rtl/logcap_cmd_sequencer.sv
// logcap_cmd_sequencer
// Takes one host request at a time and runs the LogicCaptureTop command
// handshake for it. The request command is strobed, the sequencer waits for
// the status ack, captures regOut, strobes CMD_ACK (0x08) and waits for the
// ack to drop. The captured word is then returned on the response port.
// A burst request (req_burst=1) repeats the command once per 8-byte word, and
// the host only has to consume the responses.
//
// Ports
//   clk, resetn                      clock, async active-low reset
//   req_valid/req_ready              host request handshake
//   req_cmd, req_data, req_burst     function code, {regIn7..0}, burst flag
//   rsp_valid/rsp_ready              host response handshake
//   rsp_data, rsp_last, rsp_error    {regOut7..0}, final response, error
//   command, commandStrobe, reg_in   command interface to LogicCaptureTop
//   reg_out, status                  read data and status from LogicCaptureTop
//   busy                             sequencer not idle
//
// state     | meaning
// IDLE      | waiting for a host request
// ISSUE     | strobing the latched command
// WAIT_ACK  | waiting for status ack to rise
// CAPTURE   | sampling reg_out into rsp_data
// ACKS      | strobing CMD_ACK
// WAIT_DROP | waiting for status ack to fall
// RESPOND   | presenting a response until the host takes it
module logcap_cmd_sequencer #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int ACK_BIT     = 3,
  parameter int CMD_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CMD_W-1:0] req_cmd,
  input  logic [63:0]      req_data,
  input  logic             req_burst,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             rsp_last,
  output logic             rsp_error,
  output logic [CMD_W-1:0] command,
  output logic             commandStrobe,
  output logic [63:0]      reg_in,
  input  logic [63:0]      reg_out,
  input  logic [7:0]       status,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, CAPTURE, ACKS, WAIT_DROP, RESPOND
  } state_t;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CMD_W-1:0] CMD_NOP  = '0;
  localparam logic [CMD_W-1:0] CMD_ACK  = CMD_W'(8);

  state_t           state, nextState;
  logic [CMD_W-1:0] cmdLat, cmdLatNext, commandNext;
  logic             strobeNext;
  logic [28:0]      words, wordsNext, reqWords;
  logic [CNT_W-1:0] toCnt, toCntNext;
  logic [63:0]      regInNext, rspDataNext;
  logic             rspLastNext, rspErrNext;
  logic             cmdLegal, ackSeen, toHit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESPOND);

  assign cmdLegal = ((req_cmd >= CMD_W'(1)) && (req_cmd <= CMD_W'(7))) ||
                    (req_cmd == CMD_W'(9));
  assign reqWords = req_burst ? req_data[31:3] : 29'd1;
  assign ackSeen  = status[ACK_BIT];
  // The counter value is the number of wait cycles already spent, so the
  // cycle in which it equals ACK_TIMEOUT-1 is the ACK_TIMEOUT-th one.
  assign toHit    = (toCnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cmdLat        <= CMD_NOP;
      command       <= CMD_NOP;
      commandStrobe <= 1'b0;
      words         <= '0;
      toCnt         <= '0;
      reg_in        <= '0;
      rsp_data      <= '0;
      rsp_last      <= 1'b0;
      rsp_error     <= 1'b0;
    end else begin
      state         <= nextState;
      cmdLat        <= cmdLatNext;
      command       <= commandNext;
      commandStrobe <= strobeNext;
      words         <= wordsNext;
      toCnt         <= toCntNext;
      reg_in        <= regInNext;
      rsp_data      <= rspDataNext;
      rsp_last      <= rspLastNext;
      rsp_error     <= rspErrNext;
    end
  end

  always_comb begin
    nextState   = state;
    cmdLatNext  = cmdLat;
    commandNext = command;
    strobeNext  = 1'b0;
    wordsNext   = words;
    regInNext   = reg_in;
    rspDataNext = rsp_data;
    rspLastNext = rsp_last;
    rspErrNext  = rsp_error;

    case (state)
      IDLE: begin
        if (req_valid) begin
          cmdLatNext  = req_cmd;
          regInNext   = req_data;
          wordsNext   = reqWords;
          rspDataNext = '0;
          rspLastNext = 1'b0;
          rspErrNext  = 1'b0;
          if (!cmdLegal) begin
            nextState   = RESPOND;
            rspLastNext = 1'b1;
            rspErrNext  = 1'b1;
          end else if (reqWords == 29'd0) begin
            nextState   = RESPOND;
            rspLastNext = 1'b1;
          end else begin
            nextState = ISSUE;
          end
        end
      end
      ISSUE: nextState = WAIT_ACK;
      WAIT_ACK: begin
        if (ackSeen) begin
          nextState = CAPTURE;
        end else if (toHit) begin
          nextState   = RESPOND;
          rspDataNext = '0;
          rspLastNext = 1'b1;
          rspErrNext  = 1'b1;
        end
      end
      CAPTURE: begin
        rspDataNext = reg_out;
        nextState   = ACKS;
      end
      ACKS: nextState = WAIT_DROP;
      WAIT_DROP: begin
        if (!ackSeen) begin
          nextState   = RESPOND;
          rspLastNext = (words == 29'd1);
        end else if (toHit) begin
          nextState   = RESPOND;
          rspLastNext = 1'b1;
          rspErrNext  = 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          wordsNext = words - 29'd1;
          nextState = rsp_last ? IDLE : ISSUE;
        end
      end
      default: nextState = IDLE;
    endcase

    // Strobes are registered so command and commandStrobe change together;
    // command is only reloaded on a strobe and otherwise holds.
    if (nextState == ISSUE) begin
      commandNext = cmdLatNext;
      strobeNext  = 1'b1;
    end else if (nextState == ACKS) begin
      commandNext = CMD_ACK;
      strobeNext  = 1'b1;
    end

    if (nextState != state) begin
      toCntNext = '0;
    end else if ((state == WAIT_ACK) || (state == WAIT_DROP)) begin
      toCntNext = toCnt + 1'b1;
    end else begin
      toCntNext = toCnt;
    end
  end

endmodule

// File: tb/tb_logcap_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_logcap_cmd_sequencer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [63:0] req_data = 64'h0;
  logic        req_burst = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        rsp_error;
  logic [7:0]  command;
  logic        commandStrobe;
  logic [63:0] reg_in;
  logic [63:0] reg_out = 64'h0;
  logic [7:0]  status = 8'h00;
  logic        busy;

  always #5 clk = ~clk;

  logcap_cmd_sequencer #(.ACK_TIMEOUT(TO), .ACK_BIT(3), .CMD_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_data(req_data), .req_burst(req_burst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_error(rsp_error),
    .command(command), .commandStrobe(commandStrobe), .reg_in(reg_in),
    .reg_out(reg_out), .status(status), .busy(busy)
  );

  int testCount = 0;
  int failCount = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // LogicCapture responder model
  int          ackDelay = 0;
  int          dropDelay = 1;
  int          ackCd = 0;
  int          dropCd = 0;
  int          strobes = 0;
  int          ackStrobes = 0;
  int          tickCount = 0;
  int          lastStrobeTick = 0;
  logic [63:0] nextWord = 64'h0;
  bit          prevStrobe = 1'b0;
  bit          doubleStrobe = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      tickCount++;
      if (ackCd > 0) begin
        ackCd--;
        if (ackCd == 0) begin
          status[3] = 1'b1;
          reg_out   = nextWord;
          nextWord  = nextWord + 64'd1;
        end
      end
      if (dropCd > 0) begin
        dropCd--;
        if (dropCd == 0) status[3] = 1'b0;
      end
      if (commandStrobe && prevStrobe) doubleStrobe = 1'b1;
      prevStrobe = commandStrobe;
      if (commandStrobe) begin
        if (command == 8'h08) begin
          ackStrobes++;
          dropCd = dropDelay;
        end else begin
          strobes++;
          lastStrobeTick = tickCount;
          if (ackDelay > 0) ackCd = ackDelay;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic sendReq(input logic [7:0] c, input logic [63:0] d, input logic b);
    int n;
    n = 0;
    req_cmd = c; req_data = d; req_burst = b; req_valid = 1'b1;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (!req_ready) check("req_accept_timeout", 64'd0, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  int rspTick = 0;
  task automatic waitRsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 2 * TO + 200) begin tick(); n++; end
    if (!rsp_valid) check({name, "_rsp_timeout"}, 64'd0, 64'd1);
    rspTick = tickCount;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [63:0] data;
    logic        burst;
    int          ackD;
    int          dropD;
    logic [63:0] rdVal;
    logic [63:0] expData;
    logic        expErr;
    int          expStrobes;
    int          expAcks;
    int          expLat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    int s0, a0, sc;
    logic [63:0] held;

    // strobe->response latency = ackD + dropD + 3 when acked, TO + 1 on timeout
    vecs[0]  = '{8'h04, 64'h00000014_00000070, 1'b0, 3, 1,  64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 1'b0, 1, 1, 7};
    vecs[1]  = '{8'h08, 64'h0000_0000_0000_DEAD, 1'b0, 1, 1,  64'h5,                  64'h0,                  1'b1, 0, 0, -1};
    vecs[2]  = '{8'h00, 64'h0000_0000_0000_0005, 1'b0, 1, 1,  64'h5,                  64'h0,                  1'b1, 0, 0, -1};
    vecs[3]  = '{8'h0A, 64'h0000_0000_0000_0006, 1'b0, 1, 1,  64'h5,                  64'h0,                  1'b1, 0, 0, -1};
    vecs[4]  = '{8'hFF, 64'h0000_0000_0000_0007, 1'b0, 1, 1,  64'h5,                  64'h0,                  1'b1, 0, 0, -1};
    vecs[5]  = '{8'h05, 64'h0000_0000_0000_0000, 1'b1, 1, 1,  64'h5,                  64'h0,                  1'b0, 0, 0, -1};
    vecs[6]  = '{8'h05, 64'h12345678_00000007, 1'b1, 1, 1,  64'h5,                  64'h0,                  1'b0, 0, 0, -1};
    vecs[7]  = '{8'h01, 64'h0000_0000_0000_00AA, 1'b0, 1, 1,  64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1, 1, 5};
    vecs[8]  = '{8'h09, 64'hFEDC_BA98_7654_3210, 1'b0, 2, 4,  64'h0000_0000_0000_0099, 64'h0000_0000_0000_0099, 1'b0, 1, 1, 9};
    vecs[9]  = '{8'h07, 64'h0000_0000_0000_0007, 1'b0, 1, 50, 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0001, 1'b0, 1, 1, 54};
    vecs[10] = '{8'h01, 64'h0000_0000_0000_0001, 1'b0, 0, 1,  64'h5,                  64'h0,                  1'b1, 1, 0, TO + 1};
    vecs[11] = '{8'h05, 64'h0000_0000_0000_0070, 1'b0, 1, 2,  64'h0BAD_F00D_0000_0042, 64'h0BAD_F00D_0000_0042, 1'b0, 1, 1, 6};

    // reset state
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_command", 64'(command), 64'h0);
    check("rst_strobe", 64'(commandStrobe), 64'd0);
    check("rst_reg_in", reg_in, 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_flags", 64'({rsp_last, rsp_error}), 64'd0);
    check("rst_rsp_data", rsp_data, 64'h0);
    resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      ackDelay = vecs[i].ackD; dropDelay = vecs[i].dropD; nextWord = vecs[i].rdVal;
      s0 = strobes; a0 = ackStrobes;
      sendReq(vecs[i].cmd, vecs[i].data, vecs[i].burst);
      check($sformatf("v%0d_reg_in", i), reg_in, vecs[i].data);
      waitRsp($sformatf("v%0d", i));
      check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].expData);
      check($sformatf("v%0d_rsp_last", i), 64'(rsp_last), 64'd1);
      check($sformatf("v%0d_rsp_error", i), 64'(rsp_error), 64'(vecs[i].expErr));
      check($sformatf("v%0d_strobes", i), 64'(strobes - s0), 64'(vecs[i].expStrobes));
      check($sformatf("v%0d_ack_strobes", i), 64'(ackStrobes - a0), 64'(vecs[i].expAcks));
      if (vecs[i].expLat >= 0)
        check($sformatf("v%0d_latency", i), 64'(rspTick - lastStrobeTick), 64'(vecs[i].expLat));
      if (vecs[i].expAcks > 0)
        check($sformatf("v%0d_command_hold", i), 64'(command), 64'h08);
      else if (vecs[i].expStrobes > 0)
        check($sformatf("v%0d_command_hold", i), 64'(command), 64'(vecs[i].cmd));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_valid_fall", i), 64'(rsp_valid), 64'd0);
      check($sformatf("v%0d_err_held", i), 64'(rsp_error), 64'(vecs[i].expErr));
      check($sformatf("v%0d_idle", i), 64'(req_ready), 64'd1);
      repeat (2) tick();
    end

    // burst of 112 bytes = 14 words, host stall after the 6th response
    ackDelay = 2; dropDelay = 1; nextWord = 64'h1000;
    s0 = strobes; a0 = ackStrobes;
    sendReq(8'h05, {32'hABCD_0000, 32'd112}, 1'b1);
    check("burst_reg_in", reg_in, {32'hABCD_0000, 32'd112});
    for (int w = 0; w < 14; w++) begin
      waitRsp($sformatf("burst%0d", w));
      check($sformatf("burst%0d_data", w), rsp_data, 64'h1000 + 64'(w));
      check($sformatf("burst%0d_last", w), 64'(rsp_last), 64'(w == 13));
      check($sformatf("burst%0d_error", w), 64'(rsp_error), 64'd0);
      if (w == 5) begin
        sc = strobes + ackStrobes;
        held = rsp_data;
        repeat (10) tick();
        check("burst_stall_valid", 64'(rsp_valid), 64'd1);
        check("burst_stall_strobes", 64'(strobes + ackStrobes), 64'(sc));
        check("burst_stall_data", rsp_data, held);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    check("burst_strobes", 64'(strobes - s0), 64'd14);
    check("burst_ack_strobes", 64'(ackStrobes - a0), 64'd14);
    check("burst_done_valid", 64'(rsp_valid), 64'd0);
    check("burst_done_busy", 64'(busy), 64'd0);
    repeat (2) tick();

    // back-to-back: next request accepted one cycle after the last response
    ackDelay = 1; dropDelay = 1; nextWord = 64'h77;
    sendReq(8'h02, 64'h22, 1'b0);
    waitRsp("b2b_first");
    check("b2b_first_data", rsp_data, 64'h77);
    rsp_ready = 1'b1;
    req_cmd = 8'h03; req_data = 64'h33; req_burst = 1'b0; req_valid = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("b2b_idle_ready", 64'(req_ready), 64'd1);
    check("b2b_rsp_fall", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    check("b2b_accept_strobe", 64'(commandStrobe), 64'd1);
    check("b2b_accept_cmd", 64'(command), 64'h03);
    check("b2b_accept_reg_in", reg_in, 64'h33);
    check("b2b_accept_err_clear", 64'(rsp_error), 64'd0);
    waitRsp("b2b_second");
    check("b2b_second_data", rsp_data, 64'h78);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (2) tick();

    // reset while waiting for an ack that never comes
    ackDelay = 0;
    a0 = ackStrobes;
    sendReq(8'h01, 64'hCAFE, 1'b0);
    repeat (3) tick();
    check("midrst_busy_before", 64'(busy), 64'd1);
    #3 resetn = 1'b0;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_command", 64'(command), 64'h0);
    check("midrst_strobe", 64'(commandStrobe), 64'd0);
    check("midrst_reg_in", reg_in, 64'h0);
    check("midrst_rsp", 64'({rsp_valid, rsp_last, rsp_error}), 64'd0);
    resetn = 1'b1;
    repeat (5) tick();
    check("midrst_no_ack_strobe", 64'(ackStrobes - a0), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);

    check("no_double_strobe", 64'(doubleStrobe), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
